ysyx_bus_arb: RTL and testbench
===============================

# ysyx_bus_arb

Two-master arbiter sharing one AXI4-Lite-style memory port between the instruction fetch unit (read-only) and the load/store unit (read and write). Sits between the IFU/LSU bus ports and the SoC crossbar, and owns the transaction state machine: grant, address/data handshakes, response routing, byte-lane alignment of stores and error flagging. Exactly one transaction is outstanding at a time.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ifu_araddr / ifu_arvalid  in  32 / 1  IFU read request, held until ifu_rvalid
- ifu_rdata / ifu_rvalid  out  32 / 1  IFU read data, 1-cycle valid pulse
- lsu_araddr / lsu_arvalid  in  32 / 1  LSU read request, held until lsu_rvalid
- lsu_rdata / lsu_rvalid  out  32 / 1  LSU read data, 1-cycle pulse
- lsu_awaddr, lsu_wdata  in  32  store address, unshifted store data
- lsu_wstrb  in  8  store strobe (0x1/0x3/0xf), unshifted
- lsu_awvalid / lsu_wvalid  in  1  store request, held until lsu_wready
- lsu_wready  out  1  store completion pulse
- bus_araddr, bus_arvalid / bus_arready  out,out / in  32,1 / 1  read address channel
- bus_rdata, bus_rresp, bus_rvalid / bus_rready  in / out  32,2,1 / 1  read data channel
- bus_awaddr, bus_awvalid / bus_awready  out / in  32,1 / 1  write address channel
- bus_wdata, bus_wstrb, bus_wvalid / bus_wready  out / in  32,4,1 / 1  write data channel
- bus_bresp, bus_bvalid / bus_bready  in / out  2,1 / 1  write response channel
- bus_err  out  1  1-cycle pulse on any nonzero rresp/bresp

## Operation
- States: IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R, LSU_W, LSU_B. Reset -> IDLE.
- IDLE grant order (fixed priority): LSU store (lsu_awvalid&lsu_wvalid) > LSU load > IFU fetch. Store beats load if both asserted.
- Grant latches address (and shifted data/strobe for stores) into registers; bus outputs drive only from these registers.
- *_AR: bus_arvalid=1 until bus_arready; then *_R with bus_rready=1 until bus_rvalid; that cycle: requester rvalid=1, rdata=bus_rdata (combinational pass-through, no shift), next state IDLE.
- LSU_W: bus_awvalid and bus_wvalid both asserted; each deasserts independently after its own handshake (aw_done, w_done flags); when both done -> LSU_B.
- LSU_B: bus_bready=1 until bus_bvalid; that cycle lsu_wready=1, -> IDLE.
- Store alignment: off=awaddr[1:0]; bus_wstrb = (lsu_wstrb[3:0] << off)[3:0]; bus_wdata = lsu_wdata << (8*off); bus_awaddr = full address (not word-aligned).
- Errors: rresp/bresp != 0 -> bus_err pulse same cycle as response; response still returned to the requester; FSM unaffected.
- Requests arriving while busy are not sampled; requester stalls holding valid.

## Timing
- Reset values: all *valid, *ready, lsu_wready, bus_err = 0; address/data registers = 0.
- Request seen in IDLE at cycle N -> bus_arvalid/awvalid high at N+1.
- Zero-wait slave (arready and rvalid both 1 on first opportunity): read latency 3 cycles request-to-rvalid; write 3 cycles request-to-wready.
- After any completion the FSM spends 1 cycle in IDLE; back-to-back throughput = one transaction per 3 cycles minimum.
- Requester must drop valid the cycle after its completion pulse; a still-asserted valid in IDLE is treated as a new request.
- awready and wready in same cycle -> LSU_B next cycle; in different cycles -> LSU_B the cycle after the later one.
- Reset asserted mid-transaction: immediate return to IDLE, all bus valids drop asynchronously; in-flight response is discarded.

## Configuration
- YSYX_BUS_ARB_RR_EN defined: round-robin between IFU and LSU — a 1-bit last-grant register; on contention the master not granted last wins (store still beats load within LSU). last-grant resets to IFU.
- Undefined: fixed priority as in Operation; IFU may starve under continuous LSU traffic.

## Test plan
- Single fetch: ifu_araddr=0x80000000, zero-wait slave returns 0x00000413 -> ifu_rvalid at cycle 3, ifu_rdata=0x00000413, lsu_rvalid stays 0.
- Contention: IFU and LSU load raised same cycle -> LSU granted first, IFU completes after; with RR_EN and last grant=LSU, IFU first.
- Byte store: lsu_awaddr=0x80000003, lsu_wdata=0xAB, lsu_wstrb=0x1 -> bus_wstrb=0x8, bus_wdata=0xAB000000.
- Split handshake: awready at cycle 2, wready at cycle 5, bvalid at cycle 7 -> awvalid drops after 2, wvalid after 5, lsu_wready pulse at 7.
- Error: bus_rresp=2'b10 on LSU load -> bus_err and lsu_rvalid both pulse same cycle, FSM back to IDLE.
- Reset during LSU_R wait: rst pulse -> all valids 0, state IDLE, no lsu_rvalid when slave later asserts rvalid.

Source files
------------

// File: rtl/ysyx_bus_arb.sv
// Purpose : two-master (IFU read-only, LSU read/write) arbiter onto one AXI4-Lite-style port, one transaction in flight.
// Latency : request sampled in IDLE at N -> bus valid at N+1; zero-wait slave completes at N+2 (3 cycles inclusive).
// Backpr. : requests arriving while busy are not sampled; requesters hold valid until their completion pulse.
//
// Ports   : clk/rst (async, active-high); ifu_ar*/ifu_r* fetch port; lsu_ar*/lsu_r* load port;
//           lsu_aw*/lsu_w* store port with lsu_wready completion pulse; bus_ar/r/aw/w/b* master port;
//           bus_err pulses with any nonzero rresp/bresp.
// Config  : define YSYX_BUS_ARB_RR_EN for IFU/LSU round-robin; default is fixed priority store > load > fetch.
module ysyx_bus_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic                ifu_arvalid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_rvalid,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic                lsu_arvalid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_rvalid,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [7:0]          lsu_wstrb,
    input  logic                lsu_awvalid,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    output logic [ADDR_W-1:0]   bus_araddr,
    output logic                bus_arvalid,
    input  logic                bus_arready,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic [1:0]          bus_rresp,
    input  logic                bus_rvalid,
    output logic                bus_rready,
    output logic [ADDR_W-1:0]   bus_awaddr,
    output logic                bus_awvalid,
    input  logic                bus_awready,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic                bus_wvalid,
    input  logic                bus_wready,
    input  logic [1:0]          bus_bresp,
    input  logic                bus_bvalid,
    output logic                bus_bready,
    output logic                bus_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [2:0] {
        S_IDLE, S_IFU_AR, S_IFU_R, S_LSU_AR, S_LSU_R, S_LSU_W, S_LSU_B
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_aw_done;
    logic                r_w_done;

    logic                w_store_req;
    logic                w_lsu_req;
    logic                w_lsu_wins;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic [OFF_W-1:0]    w_off;
    logic [DATA_W-1:0]   w_wdata_sh;
    logic [STRB_W-1:0]   w_wstrb_sh;
    // Strobe input is wider than a 32-bit lane set; the surplus bits carry nothing.
    logic                w_unused;

    assign w_unused    = &{1'b0, lsu_wstrb};
    assign w_store_req = lsu_awvalid & lsu_wvalid;
    assign w_lsu_req   = w_store_req | lsu_arvalid;

`ifdef YSYX_BUS_ARB_RR_EN
    // 1 = LSU received the most recent grant; on contention the other master wins.
    logic r_last_lsu;
    assign w_lsu_wins = w_lsu_req & (~ifu_arvalid | ~r_last_lsu);
`else
    assign w_lsu_wins = w_lsu_req;
`endif

    // Stores arrive lane-0 aligned; move data and strobe onto the addressed byte lanes.
    assign w_off      = lsu_awaddr[OFF_W-1:0];
    assign w_wdata_sh = lsu_wdata << {w_off, 3'b000};
    assign w_wstrb_sh = lsu_wstrb[STRB_W-1:0] << w_off;

    // AW and W complete independently; each handshake is counted only once.
    assign w_aw_hs = (r_state == S_LSU_W) & ~r_aw_done & bus_awready;
    assign w_w_hs  = (r_state == S_LSU_W) & ~r_w_done  & bus_wready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_lsu_wins)       w_state_nxt = w_store_req ? S_LSU_W : S_LSU_AR;
                else if (ifu_arvalid) w_state_nxt = S_IFU_AR;
            end
            S_IFU_AR: if (bus_arready) w_state_nxt = S_IFU_R;
            S_IFU_R:  if (bus_rvalid)  w_state_nxt = S_IDLE;
            S_LSU_AR: if (bus_arready) w_state_nxt = S_LSU_R;
            S_LSU_R:  if (bus_rvalid)  w_state_nxt = S_IDLE;
            S_LSU_W:  if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) w_state_nxt = S_LSU_B;
            S_LSU_B:  if (bus_bvalid)  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE) begin
                if (w_lsu_wins && w_store_req) begin
                    r_addr  <= lsu_awaddr;
                    r_wdata <= w_wdata_sh;
                    r_wstrb <= w_wstrb_sh;
                end else if (w_lsu_wins) begin
                    r_addr <= lsu_araddr;
                end else if (ifu_arvalid) begin
                    r_addr <= ifu_araddr;
                end
            end
            // Done flags live only for the duration of the write-address/data phase.
            r_aw_done <= (r_state == S_LSU_W) & (r_aw_done | w_aw_hs);
            r_w_done  <= (r_state == S_LSU_W) & (r_w_done  | w_w_hs);
        end
    end

`ifdef YSYX_BUS_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_lsu <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_lsu_wins)       r_last_lsu <= 1'b1;
            else if (ifu_arvalid) r_last_lsu <= 1'b0;
        end
    end
`endif

    assign bus_araddr  = r_addr;
    assign bus_awaddr  = r_addr;
    assign bus_wdata   = r_wdata;
    assign bus_wstrb   = r_wstrb;
    assign bus_arvalid = (r_state == S_IFU_AR) | (r_state == S_LSU_AR);
    assign bus_rready  = (r_state == S_IFU_R)  | (r_state == S_LSU_R);
    assign bus_awvalid = (r_state == S_LSU_W) & ~r_aw_done;
    assign bus_wvalid  = (r_state == S_LSU_W) & ~r_w_done;
    assign bus_bready  = (r_state == S_LSU_B);

    // Read data is passed straight through; only the owning requester sees rvalid.
    assign ifu_rdata   = bus_rdata;
    assign lsu_rdata   = bus_rdata;
    assign ifu_rvalid  = (r_state == S_IFU_R) & bus_rvalid;
    assign lsu_rvalid  = (r_state == S_LSU_R) & bus_rvalid;
    assign lsu_wready  = (r_state == S_LSU_B) & bus_bvalid;
    assign bus_err     = (bus_rready & bus_rvalid & (|bus_rresp)) |
                         (bus_bready & bus_bvalid & (|bus_bresp));

endmodule

// File: tb/tb_ysyx_bus_arb.sv
module tb_ysyx_bus_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr, ifu_rdata, lsu_araddr, lsu_rdata, lsu_awaddr, lsu_wdata;
    logic        ifu_arvalid, ifu_rvalid, lsu_arvalid, lsu_rvalid;
    logic [7:0]  lsu_wstrb;
    logic        lsu_awvalid, lsu_wvalid, lsu_wready;
    logic [31:0] bus_araddr, bus_rdata, bus_awaddr, bus_wdata;
    logic        bus_arvalid, bus_arready, bus_rvalid, bus_rready;
    logic [1:0]  bus_rresp, bus_bresp;
    logic        bus_awvalid, bus_awready, bus_wvalid, bus_wready, bus_bvalid, bus_bready, bus_err;
    logic [3:0]  bus_wstrb;

    always #5 clk = ~clk;

    ysyx_bus_arb dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
        .lsu_awaddr(lsu_awaddr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_awvalid(lsu_awvalid), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .bus_araddr(bus_araddr), .bus_arvalid(bus_arvalid), .bus_arready(bus_arready),
        .bus_rdata(bus_rdata), .bus_rresp(bus_rresp), .bus_rvalid(bus_rvalid), .bus_rready(bus_rready),
        .bus_awaddr(bus_awaddr), .bus_awvalid(bus_awvalid), .bus_awready(bus_awready),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_wvalid(bus_wvalid), .bus_wready(bus_wready),
        .bus_bresp(bus_bresp), .bus_bvalid(bus_bvalid), .bus_bready(bus_bready),
        .bus_err(bus_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- transaction-level reference model ----------------
    // One outstanding transaction; the pending channels of that transaction are
    // tracked as tokens that are consumed by slave handshakes.
    bit          m_busy, ar_pend, r_pend, aw_pend, w_pend, b_pend, m_last_lsu;
    int          m_who;   // 0 fetch, 1 load, 2 store
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    bit          f_ifu_done, f_lsu_done;

    always @(negedge clk) begin
        bit e_ifu_rv, e_lsu_rv, e_wr, e_err, st, ld, fe, lsu_go;
        int off, tmp;
        if (rst) begin
            m_busy = 0; ar_pend = 0; r_pend = 0; aw_pend = 0; w_pend = 0; b_pend = 0;
            m_last_lsu = 0; m_who = 0;
        end
        e_ifu_rv = r_pend && m_who == 0 && bus_rvalid;
        e_lsu_rv = r_pend && m_who == 1 && bus_rvalid;
        e_wr     = b_pend && bus_bvalid;
        e_err    = (r_pend && bus_rvalid && bus_rresp != 0) || (b_pend && bus_bvalid && bus_bresp != 0);
        chk1("ifu_rvalid", ifu_rvalid, e_ifu_rv);
        chk1("lsu_rvalid", lsu_rvalid, e_lsu_rv);
        chk1("lsu_wready", lsu_wready, e_wr);
        chk1("bus_err", bus_err, e_err);
        chk1("bus_arvalid", bus_arvalid, ar_pend);
        chk1("bus_rready", bus_rready, r_pend);
        chk1("bus_awvalid", bus_awvalid, aw_pend);
        chk1("bus_wvalid", bus_wvalid, w_pend);
        chk1("bus_bready", bus_bready, b_pend);
        if (e_ifu_rv) chk32("ifu_rdata", ifu_rdata, bus_rdata);
        if (e_lsu_rv) chk32("lsu_rdata", lsu_rdata, bus_rdata);
        if (ar_pend)  chk32("bus_araddr", bus_araddr, m_addr);
        if (aw_pend)  chk32("bus_awaddr", bus_awaddr, m_addr);
        if (w_pend) begin
            chk32("bus_wdata", bus_wdata, m_wdata);
            chk32("bus_wstrb", 32'(bus_wstrb), 32'(m_wstrb));
        end
        f_ifu_done = e_ifu_rv;
        f_lsu_done = e_lsu_rv || e_wr;
        if (!rst) begin
            if (!m_busy) begin
                st = lsu_awvalid && lsu_wvalid;
                ld = lsu_arvalid;
                fe = ifu_arvalid;
`ifdef YSYX_BUS_ARB_RR_EN
                lsu_go = (st || ld) && (!fe || !m_last_lsu);
`else
                lsu_go = st || ld;
`endif
                if (lsu_go && st) begin
                    m_busy = 1; m_who = 2; aw_pend = 1; w_pend = 1; m_last_lsu = 1;
                    m_addr  = lsu_awaddr;
                    off     = int'(lsu_awaddr[1:0]);
                    m_wdata = lsu_wdata << (8 * off);
                    tmp     = int'(lsu_wstrb[3:0]) << off;
                    m_wstrb = tmp[3:0];
                end else if (lsu_go) begin
                    m_busy = 1; m_who = 1; ar_pend = 1; m_last_lsu = 1; m_addr = lsu_araddr;
                end else if (fe) begin
                    m_busy = 1; m_who = 0; ar_pend = 1; m_last_lsu = 0; m_addr = ifu_araddr;
                end
            end else if (ar_pend) begin
                if (bus_arready) begin ar_pend = 0; r_pend = 1; end
            end else if (r_pend) begin
                if (bus_rvalid) begin r_pend = 0; m_busy = 0; end
            end else if (aw_pend || w_pend) begin
                if (aw_pend && bus_awready) aw_pend = 0;
                if (w_pend && bus_wready)   w_pend = 0;
                if (!aw_pend && !w_pend)    b_pend = 1;
            end else if (b_pend && bus_bvalid) begin
                b_pend = 0; m_busy = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic zero_wait_slave(input logic [31:0] rdata, input logic [1:0] resp);
        bus_arready = 1; bus_rvalid = 1; bus_rdata = rdata; bus_rresp = resp;
        bus_awready = 1; bus_wready = 1; bus_bvalid = 1; bus_bresp = 0;
    endtask

    logic first_ifu;

    initial begin
`ifdef YSYX_BUS_ARB_RR_EN
        first_ifu = 1'b1;
`else
        first_ifu = 1'b0;
`endif
        rst = 1;
        ifu_araddr = 0; ifu_arvalid = 0; lsu_araddr = 0; lsu_arvalid = 0;
        lsu_awaddr = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_awvalid = 0; lsu_wvalid = 0;
        bus_arready = 0; bus_rdata = 0; bus_rresp = 0; bus_rvalid = 0;
        bus_awready = 0; bus_wready = 0; bus_bresp = 0; bus_bvalid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst arvalid", bus_arvalid, 1'b0);
        chk1("rst awvalid", bus_awvalid, 1'b0);
        chk1("rst wvalid", bus_wvalid, 1'b0);
        tick(); rst = 0;
        @(negedge clk);
        chk32("rst araddr", bus_araddr, 32'h0);
        chk32("rst wdata", bus_wdata, 32'h0);
        chk32("rst wstrb", 32'(bus_wstrb), 32'h0);

        // single fetch, zero-wait slave
        tick(); ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; zero_wait_slave(32'h0000_0413, 2'b00);
        @(negedge clk); chk1("fetch idle rvalid", ifu_rvalid, 1'b0);
        tick(); @(negedge clk);
        chk1("fetch arvalid", bus_arvalid, 1'b1);
        chk32("fetch araddr", bus_araddr, 32'h8000_0000);
        tick(); @(negedge clk);
        chk1("fetch rvalid", ifu_rvalid, 1'b1);
        chk32("fetch rdata", ifu_rdata, 32'h0000_0413);
        chk1("fetch lsu_rvalid", lsu_rvalid, 1'b0);
        tick(); ifu_arvalid = 0;

        // byte store competing with a load: store first, then the held load
        lsu_awaddr = 32'h8000_0003; lsu_wdata = 32'hAB; lsu_wstrb = 8'h01;
        lsu_awvalid = 1; lsu_wvalid = 1; lsu_arvalid = 1; lsu_araddr = 32'h8000_1000;
        zero_wait_slave(32'hCAFE_F00D, 2'b00);
        @(negedge clk);
        tick(); @(negedge clk);
        chk1("store awvalid", bus_awvalid, 1'b1);
        chk1("store beats load", bus_arvalid, 1'b0);
        chk32("store wstrb", 32'(bus_wstrb), 32'h8);
        chk32("store wdata", bus_wdata, 32'hAB00_0000);
        chk32("store awaddr", bus_awaddr, 32'h8000_0003);
        tick(); @(negedge clk);
        chk1("store wready", lsu_wready, 1'b1);
        tick(); lsu_awvalid = 0; lsu_wvalid = 0;
        @(negedge clk); chk1("store wready pulse", lsu_wready, 1'b0);
        tick(); @(negedge clk); chk32("held load araddr", bus_araddr, 32'h8000_1000);
        tick(); @(negedge clk);
        chk1("held load rvalid", lsu_rvalid, 1'b1);
        chk32("held load rdata", lsu_rdata, 32'hCAFE_F00D);
        tick(); lsu_arvalid = 0;

        // split AW/W handshake
        lsu_awaddr = 32'h8000_0002; lsu_wdata = 32'h1234; lsu_wstrb = 8'h03;
        lsu_awvalid = 1; lsu_wvalid = 1; bus_awready = 0; bus_wready = 0; bus_bvalid = 0;
        @(negedge clk);
        tick(); bus_awready = 1; @(negedge clk);
        chk1("split aw c2", bus_awvalid, 1'b1);
        chk32("split wstrb", 32'(bus_wstrb), 32'hC);
        chk32("split wdata", bus_wdata, 32'h1234_0000);
        tick(); bus_awready = 0; @(negedge clk);
        chk1("split aw dropped", bus_awvalid, 1'b0);
        chk1("split w held", bus_wvalid, 1'b1);
        tick(); @(negedge clk);
        tick(); bus_wready = 1; @(negedge clk); chk1("split w c5", bus_wvalid, 1'b1);
        tick(); bus_wready = 0; @(negedge clk);
        chk1("split w dropped", bus_wvalid, 1'b0);
        chk1("split bready", bus_bready, 1'b1);
        tick(); bus_bvalid = 1; @(negedge clk); chk1("split wready c7", lsu_wready, 1'b1);
        tick(); bus_bvalid = 0; lsu_awvalid = 0; lsu_wvalid = 0;

        // error response on a load
        lsu_arvalid = 1; lsu_araddr = 32'h8000_2000; zero_wait_slave(32'h55, 2'b10);
        @(negedge clk);
        tick(); @(negedge clk);
        tick(); @(negedge clk);
        chk1("err lsu_rvalid", lsu_rvalid, 1'b1);
        chk1("err pulse", bus_err, 1'b1);
        tick(); lsu_arvalid = 0; @(negedge clk);
        chk1("err cleared", bus_err, 1'b0);
        chk1("err back idle", bus_arvalid, 1'b0);
        tick(); bus_rresp = 0;

        // contention: last grant was LSU here
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0100;
        lsu_arvalid = 1; lsu_araddr = 32'h8000_0200; zero_wait_slave(32'h1111_1111, 2'b00);
        @(negedge clk);
        tick(); @(negedge clk);
        chk32("cont first araddr", bus_araddr, first_ifu ? 32'h8000_0100 : 32'h8000_0200);
        tick(); @(negedge clk);
        chk1("cont first ifu_rvalid", ifu_rvalid, first_ifu);
        chk1("cont first lsu_rvalid", lsu_rvalid, !first_ifu);
        tick(); if (first_ifu) ifu_arvalid = 0; else lsu_arvalid = 0;
        @(negedge clk);
        tick(); @(negedge clk);
        chk32("cont second araddr", bus_araddr, first_ifu ? 32'h8000_0200 : 32'h8000_0100);
        tick(); @(negedge clk);
        chk1("cont second ifu_rvalid", ifu_rvalid, !first_ifu);
        chk1("cont second lsu_rvalid", lsu_rvalid, first_ifu);
        tick(); ifu_arvalid = 0; lsu_arvalid = 0;

        // reset while waiting for read data
        lsu_arvalid = 1; lsu_araddr = 32'h8000_3000; bus_arready = 1; bus_rvalid = 0;
        @(negedge clk);
        tick(); @(negedge clk);
        tick(); @(negedge clk); chk1("rstmid rready", bus_rready, 1'b1);
        tick(); rst = 1; lsu_arvalid = 0;
        #1;
        chk1("rstmid async rready", bus_rready, 1'b0);
        chk1("rstmid async arvalid", bus_arvalid, 1'b0);
        @(negedge clk);
        tick(); rst = 0; bus_rvalid = 1; @(negedge clk);
        chk1("rstmid no rvalid", lsu_rvalid, 1'b0);
        tick(); @(negedge clk);
        chk1("rstmid still no rvalid", lsu_rvalid, 1'b0);

        // randomized traffic with random slave timing and occasional reset
        for (int c = 0; c < 4000; c++) begin
            tick();
            bus_arready = 1'($urandom_range(0, 1));
            bus_rvalid  = ($urandom_range(0, 2) == 0);
            bus_rdata   = $urandom;
            bus_rresp   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bus_awready = 1'($urandom_range(0, 1));
            bus_wready  = 1'($urandom_range(0, 1));
            bus_bvalid  = ($urandom_range(0, 2) == 0);
            bus_bresp   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (c % 1000 == 700) begin
                rst = 1;
                ifu_arvalid = 0; lsu_arvalid = 0; lsu_awvalid = 0; lsu_wvalid = 0;
            end else begin
                rst = 0;
                if (ifu_arvalid) begin
                    if (f_ifu_done) ifu_arvalid = 0;
                end else if ($urandom_range(0, 3) == 0) begin
                    ifu_arvalid = 1; ifu_araddr = $urandom;
                end
                if (lsu_arvalid || lsu_awvalid) begin
                    if (f_lsu_done) begin
                        lsu_arvalid = 0; lsu_awvalid = 0; lsu_wvalid = 0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 1) == 1) begin
                        lsu_awaddr = $urandom; lsu_wdata = $urandom;
                        case ($urandom_range(0, 2))
                            0:       lsu_wstrb = 8'h01;
                            1:       lsu_wstrb = 8'h03;
                            default: lsu_wstrb = 8'h0f;
                        endcase
                        lsu_awvalid = 1; lsu_wvalid = 1;
                    end else begin
                        lsu_araddr = $urandom; lsu_arvalid = 1;
                    end
                end
            end
        end
        tick(); rst = 0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
